// File: rtl/fifo_rd_ptr_empty.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_ptr_empty
// Description : Read-side pointer/flag stage of an async FIFO. Synchronises
//               the write-pointer gray code into the read domain, owns the
//               read pointer (binary + gray), and produces the RAM read
//               address, registered empty flag, fill level and a sticky
//               underflow flag.
//               Optional: define FIFO_RD_AEMPTY_EN to add the almost_empty
//               output (level at or below AEMPTY_TH).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_ptr_empty #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AEMPTY_TH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   wptr_gray,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rptr_gray,
  output logic              empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              underflow
`ifdef FIFO_RD_AEMPTY_EN
  ,
  output logic              almost_empty
`endif
);

  // Reject illegal configurations at elaboration time.
  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4) || (ADDR_W < 1) ||
      (AEMPTY_TH < 0)) begin : g_param_check
    $error("fifo_rd_ptr_empty: illegal parameter set");
  end

  localparam logic [ADDR_W:0] C_ZERO = '0;

  // Synchroniser chain: stage 0 captures the asynchronous input, last stage is wq.
  logic [SYNC_STAGES-1:0][ADDR_W:0] sync_q, sync_d;
  logic [ADDR_W:0] wq;
  logic [ADDR_W:0] wbin;

  // Read pointer, flags and level state.
  logic [ADDR_W:0] rbin_q, rbin_d;
  logic [ADDR_W:0] rgray_q, rgray_d;
  logic            empty_q, empty_d;
  logic [ADDR_W:0] level_q, level_d;
  logic            underflow_q, underflow_d;
  logic            rd_fire;

  assign wq = sync_q[SYNC_STAGES-1];

  // Shift the write-pointer gray code one stage per clock.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = wptr_gray;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Gray-to-binary of the synchronised write pointer: bit i is the XOR of all bits at and above i.
  always_comb begin
    wbin = C_ZERO;
    for (int i = 0; i <= ADDR_W; i++) begin
      wbin[i] = ^(wq >> i);
    end
  end

  // Next read pointer, empty flag, level and sticky underflow.
  always_comb begin
    rd_fire     = rd_en & ~empty_q;
    rbin_d      = rbin_q + {C_ZERO[ADDR_W:1], rd_fire};
    rgray_d     = rbin_d ^ (rbin_d >> 1);
    // Compared against wq directly so empty asserts on the edge of the last read.
    empty_d     = (rgray_d == wq);
    // Natural modulo 2^(ADDR_W+1) subtraction; a full FIFO yields 2^ADDR_W.
    level_d     = wbin - rbin_d;
    underflow_d = underflow_q | (rd_en & empty_q);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      rbin_q      <= '0;
      rgray_q     <= '0;
      empty_q     <= 1'b1;
      level_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      rbin_q      <= rbin_d;
      rgray_q     <= rgray_d;
      empty_q     <= empty_d;
      level_q     <= level_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef FIFO_RD_AEMPTY_EN
  localparam logic [ADDR_W:0] C_AEMPTY_TH = AEMPTY_TH[ADDR_W:0];

  logic almost_empty_q, almost_empty_d;

  // Almost-empty tracks the same level value that is loaded into rd_level.
  always_comb begin
    almost_empty_d = (level_d <= C_AEMPTY_TH);
  end

  // Almost-empty register, set on reset since the FIFO starts empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      almost_empty_q <= 1'b1;
    end else begin
      almost_empty_q <= almost_empty_d;
    end
  end

  assign almost_empty = almost_empty_q;
`endif

  assign rd_addr   = rbin_q[ADDR_W-1:0];
  assign rptr_gray = rgray_q;
  assign empty     = empty_q;
  assign rd_level  = level_q;
  assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ptr_empty.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_ptr_empty
// Description : Directed self-checking bench for fifo_rd_ptr_empty
//               (ADDR_W=4, SYNC_STAGES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_ptr_empty;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_en;
  logic [ADDR_W:0]   wptr_gray;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   rptr_gray;
  logic              empty;
  logic [ADDR_W:0]   rd_level;
  logic              underflow;
`ifdef FIFO_RD_AEMPTY_EN
  logic              almost_empty;
`endif

  int total = 0;
  int bad   = 0;

  fifo_rd_ptr_empty #(
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (2),
    .AEMPTY_TH   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_en        (rd_en),
    .wptr_gray    (wptr_gray),
    .rd_addr      (rd_addr),
    .rptr_gray    (rptr_gray),
    .empty        (empty),
    .rd_level     (rd_level),
    .underflow    (underflow)
`ifdef FIFO_RD_AEMPTY_EN
    ,
    .almost_empty (almost_empty)
`endif
  );

  always #5 clk = ~clk;

  // One clock edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    rd_en     = 1'b0;
    wptr_gray = 5'b00000;

    // 1. Reset state
    repeat (3) tick();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_rptr", 32'(rptr_gray), 32'd0);
    check("rst_addr", 32'(rd_addr), 32'd0);
    check("rst_level", 32'(rd_level), 32'd0);
    check("rst_uflow", 32'(underflow), 32'd0);
`ifdef FIFO_RD_AEMPTY_EN
    check("rst_aempty", 32'(almost_empty), 32'd1);
`endif
    rst = 1'b0;

    // 2. Write pointer steps 0->1->2->3 (gray 00001, 00011, 00010)
    wptr_gray = 5'b00001;
    tick();
    check("w_e1_empty", 32'(empty), 32'd1);
    wptr_gray = 5'b00011;
    tick();
    check("w_e2_empty", 32'(empty), 32'd1);
    wptr_gray = 5'b00010;
    tick();
    check("w_e3_empty", 32'(empty), 32'd0);
    check("w_e3_level", 32'(rd_level), 32'd1);
    tick();
    check("w_e4_level", 32'(rd_level), 32'd2);
    tick();
    check("w_e5_level", 32'(rd_level), 32'd3);
    check("w_e5_addr", 32'(rd_addr), 32'd0);

    // 3. Drain three entries, then one read into an empty FIFO
    rd_en = 1'b1;
    tick();
    check("r1_rptr", 32'(rptr_gray), 32'h01);
    check("r1_addr", 32'(rd_addr), 32'd1);
    check("r1_level", 32'(rd_level), 32'd2);
    check("r1_empty", 32'(empty), 32'd0);
    tick();
    check("r2_rptr", 32'(rptr_gray), 32'h03);
    check("r2_level", 32'(rd_level), 32'd1);
    tick();
    check("r3_rptr", 32'(rptr_gray), 32'h02);
    check("r3_empty", 32'(empty), 32'd1);
    check("r3_level", 32'(rd_level), 32'd0);
    check("r3_uflow", 32'(underflow), 32'd0);
    tick();
    check("r4_uflow", 32'(underflow), 32'd1);
    check("r4_rptr", 32'(rptr_gray), 32'h02);
    check("r4_addr", 32'(rd_addr), 32'd3);
    rd_en = 1'b0;

    // 6. Advance writer to bin 7 (gray 00100), read to rbin=7, then mid-stream reset
    wptr_gray = 5'b00100;
    repeat (3) tick();
    check("m_level", 32'(rd_level), 32'd4);
    check("m_empty", 32'(empty), 32'd0);
    rd_en = 1'b1;
    repeat (4) tick();
    check("m_addr7", 32'(rd_addr), 32'd7);
    check("m_rptr7", 32'(rptr_gray), 32'h04);
    check("m_uflow", 32'(underflow), 32'd1);
    rst = 1'b1;
    tick();
    check("mr_rptr", 32'(rptr_gray), 32'd0);
    check("mr_empty", 32'(empty), 32'd1);
    check("mr_level", 32'(rd_level), 32'd0);
    check("mr_uflow", 32'(underflow), 32'd0);
    rst   = 1'b0;
    rd_en = 1'b0;

    // 5. Full: rbin=0, writer at bin 16 (gray 11000)
    wptr_gray = 5'b11000;
    repeat (2) tick();
    check("f_e2_empty", 32'(empty), 32'd1);
    tick();
    check("f_level", 32'(rd_level), 32'd16);
    check("f_empty", 32'(empty), 32'd0);

    // Drain all 16 entries; empty only on the last read
    rd_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("f_rd%0d_empty", k), 32'(empty), (k == 16) ? 32'd1 : 32'd0);
      check($sformatf("f_rd%0d_level", k), 32'(rd_level), 32'(16 - k));
    end
    rd_en = 1'b0;

    // 4. Wrap: writer to bin 31 (gray 10000), read up to rbin=31
    wptr_gray = 5'b10000;
    repeat (3) tick();
    check("wr_level15", 32'(rd_level), 32'd15);
    rd_en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("wr_rd%0d_empty", k), 32'(empty), (k == 15) ? 32'd1 : 32'd0);
    end
    rd_en = 1'b0;
    check("wr_rptr31", 32'(rptr_gray), 32'h10);
    check("wr_addr15", 32'(rd_addr), 32'd15);

    // Writer wraps to bin 0; one entry across the wrap
    wptr_gray = 5'b00000;
    repeat (3) tick();
    check("wr0_empty", 32'(empty), 32'd0);
    check("wr0_level", 32'(rd_level), 32'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("wr0_rptr", 32'(rptr_gray), 32'd0);
    check("wr0_addr", 32'(rd_addr), 32'd0);
    check("wr0_empty2", 32'(empty), 32'd1);
    check("wr0_level2", 32'(rd_level), 32'd0);
    check("wr0_uflow", 32'(underflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_rd_ptr_empty.md
Name: fifo_rd_ptr_empty

Overview:
Read-side pointer and flag stage of the async FIFO, directly downstream of the write-domain gray_counter.
- Synchronises the incoming write-pointer gray code into the read clock domain.
- Owns the local read pointer (binary and gray).
- Produces the RAM read address, a registered empty flag, the fill level and a sticky underflow flag.
- Its rptr_gray output crosses back to the write side for full detection.

Parameters:
ADDR_W, 4, RAM address width; pointers are ADDR_W+1 bits, depth 2^ADDR_W
SYNC_STAGES, 2, flops in wptr_gray synchroniser, legal range 2..4
AEMPTY_TH, 2, almost-empty threshold in entries (used only with FIFO_RD_AEMPTY_EN)

Ports:
clk  in  1  read-domain clock, all logic on rising edge
rst  in  1  synchronous active-high reset
rd_en  in  1  read request from consumer
wptr_gray  in  ADDR_W+1  write pointer gray code from write domain (asynchronous to clk)
rd_addr  out  ADDR_W  RAM read address
rptr_gray  out  ADDR_W+1  registered read pointer gray code, to write-domain synchroniser
empty  out  1  registered FIFO empty flag
rd_level  out  ADDR_W+1  registered occupancy as seen by read side, 0..2^ADDR_W
underflow  out  1  sticky: set by rd_en while empty
almost_empty  out  1  present only with FIFO_RD_AEMPTY_EN

Behaviour:
Reset and clocking
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values, all taking effect at the next clk edge with rst=1: rbin=0, rptr_gray=0, all synchroniser flops=0, empty=1, rd_level=0, underflow=0, almost_empty=1.
- Reset mid-operation: the same values apply at that edge regardless of rd_en or wptr_gray. The write side is reset in the same system reset sequence; a mismatch is not corrected here.

Synchroniser
- wptr_gray passes through SYNC_STAGES flops; wq = last stage.
- Latency from a wptr_gray change to wq is SYNC_STAGES edges.
- wptr_gray changes by at most one bit between successive values, since it is driven from a gray counter.
- wbin = gray-to-binary(wq), combinational: bit i = XOR of wq[ADDR_W:i].

Read pointer
- rd_fire = rd_en & ~empty.
- rbin_next = rbin + rd_fire, modulo 2^(ADDR_W+1); wrap from all-ones to 0 is natural.
- rgray_next = rbin_next ^ (rbin_next >> 1).
- rbin and rptr_gray are registered from the _next values.
- rd_addr = rbin[ADDR_W-1:0]. Data for the current address is valid while empty=0; consumer samples on the rd_fire edge.
- rd_en with empty=1: ignored; pointers unchanged; underflow<=1.
- underflow clears only on rst.

Flags and level
- empty <= (rgray_next == wq). Empty therefore deasserts SYNC_STAGES+1 edges after a write-pointer change and asserts on the same edge as the last read.
- rd_level <= (wbin - rbin_next) mod 2^(ADDR_W+1).
  - Full FIFO (MSBs differ, lower bits equal) gives 2^ADDR_W.
  - Values above 2^ADDR_W are not produced while the writer honours full; the block does not check for them.
- Simultaneous rd_fire and wq change: both are used in the same next-state computation; no priority is needed.

Optional Feature:
FIFO_RD_AEMPTY_EN
- Defined: almost_empty port exists. almost_empty <= (level_next <= AEMPTY_TH), where level_next is the same value loaded into rd_level. Reset value 1.
- Undefined: port and logic are absent; AEMPTY_TH is unused.

Test Plan:
All scenarios use ADDR_W=4, SYNC_STAGES=2.
1. rst=1 for 3 edges, wptr_gray=0 -> empty=1, rptr_gray=5'b00000, rd_addr=0, rd_level=0, underflow=0 (almost_empty=1 if enabled).
2. After reset, wptr_gray steps 00000->00001->00011->00010 on consecutive edges, then holds at bin 3 -> empty falls 3 edges after the first step; rd_level=3 once wq=00010.
3. With 3 entries, rd_en=1 for 4 edges -> rptr_gray 00001, 00011, 00010; empty=1 on the 3rd read edge; 4th rd_en sets underflow=1; rptr_gray stays 00010, rd_addr=3.
4. Wrap: write pointer advanced to bin 31 then 0 (gray 10000 then 00000) with reads following -> rbin 31->0, rptr_gray 10000->00000, rd_addr 15->0; empty asserts only when the pointers match.
5. Full: rbin=0, wptr_gray=5'b11000 (bin 16) -> after sync, rd_level=16, empty=0.
6. Mid-stream rst=1 for one edge with rbin=7 and underflow=1 -> next edge rptr_gray=0, empty=1, rd_level=0, underflow=0.
